mul16_seq: RTL and testbench
============================

# mul16_seq

Sequential 16-bit multiplier controller for the Hack arithmetic library. It sequences a single internal `add16` instance through a shift-and-add loop, producing the low 16 bits of `a*b` with a start/busy/done handshake. It gives the ALU/CPU layer multiplication without a combinational array multiplier. It is the first sequential consumer of the `add16` datapath.

## Interface
- No parameters; width fixed at 16.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  request; accepted only on an edge where `busy`=0.
- `a`  in  16  multiplicand; sampled on the accepting edge only.
- `b`  in  16  multiplier; sampled on the accepting edge only.
- `busy`  out  1  high while the state is RUN.
- `done`  out  1  one-cycle pulse; high during the DONE state.
- `out`  out  16  product, low 16 bits of `a*b` (mod 2^16); registered.

## Operation
- **States:**
  - IDLE: `busy`=0, `done`=0.
  - RUN: `busy`=1, `done`=0.
  - DONE: `busy`=0, `done`=1.
- **Internal registers:**
  - `mcand` (16 bits): shifted multiplicand.
  - `mplier` (16 bits): shifted multiplier.
  - `acc` (16 bits): accumulator.
  - `cnt` (4 bits): bit counter.
- **IDLE or DONE with `start`=1:**
  - Load `mcand`=`a`, `mplier`=`b`, `acc`=0, `cnt`=0.
  - Next state is RUN.
- **IDLE or DONE with `start`=0:**
  - DONE goes to IDLE.
  - IDLE stays in IDLE.
- **RUN, each edge:**
  - The `add16` instance computes `acc + (mplier[0] ? mcand : 0)`.
  - `acc` <= that sum. The carry out of bit 15 is discarded.
  - `mcand` <= `mcand` << 1, zero fill.
  - `mplier` <= `mplier` >> 1, zero fill.
  - `cnt` <= `cnt` + 1.
- **RUN exit:** on the edge where `cnt`=15, go to DONE and load `out` <= the new `acc` value.
- **`start` while `busy`=1:** ignored; no effect on the operation in flight.
- **`out` holding:**
  - `out` changes only on the RUN→DONE edge and on reset.
  - Between those, it holds the last completed product, including through a subsequent RUN.
- **Overflow:** bits above 15 are dropped. Operands are treated as unsigned. The low 16 bits are identical for two's-complement signed operands.

## Timing
- **Reset:** state=IDLE, `busy`=0, `done`=0, `out`=0x0000. Internal registers are cleared.
- **Reset precedence:** reset overrides `start` and any state. Reset mid-RUN aborts the operation: no `done` pulse, and `out` is 0.
- **Latency (macro off):**
  - Accepting edge E0.
  - RUN occupies the cycles after E0 through E15.
  - Edge E16 enters DONE. `done`=1 and `out` is valid in the cycle after E16.
  - E17 returns to IDLE, unless `start`=1 at E17.
- **Back-to-back:** `start` held high during the DONE cycle is accepted at E17.
  - `done` drops and RUN begins. `out` keeps the previous product.
  - Throughput is one product per 17 cycles.
- **`done`:** never high for more than one consecutive cycle.
- **Busy/done exclusivity:** `busy` and `done` are never both high.

## Configuration
- **Macro:** `MUL16_EARLY_EXIT_EN`.
- **Defined:**
  - RUN also exits on the edge where the new `mplier` is zero. The exit condition becomes `cnt`=15 OR (`mplier`>>1)=0.
  - RUN length is max(1, position of the highest set bit of `b` + 1) cycles.
  - `b`=0 gives exactly one RUN cycle and `out`=0.
  - The result value is identical to the macro-off result.
- **Undefined:** RUN is always 16 cycles and latency is fixed as given under Timing. The early-exit comparator is not present.

## Test plan
- Reset, then `a`=3, `b`=5, `start`=1 for one cycle → `busy`=1 for 16 cycles; `done`=1 on the 17th cycle after the accepting edge, `out`=15 (0x000F).
- `a`=0xFFFF, `b`=0xFFFF → `out`=0x0001. Also `a`=0x0100, `b`=0x0100 → `out`=0x0000 (overflow dropped).
- Pulse `start` at RUN cycle 5 with `a`=7, `b`=7 while computing 3*5 → ignored; result is 15, then IDLE.
- Assert `reset` at RUN cycle 8 of 0x1234*0x0002 → next cycle `busy`=0, `done`=0, `out`=0. No `done` pulse appears afterwards.
- Hold `start`=1 through the DONE cycle of 3*5, with new operands 2*9 → `done` high for exactly one cycle with `out`=15. The next `done` shows `out`=18, 17 cycles later.
- With `MUL16_EARLY_EXIT_EN`: `b`=1 → `done` 2 cycles after the accepting edge; `b`=0x0005 → 4 cycles; `b`=0 → 2 cycles with `out`=0. Without the macro, all three take 17 cycles.

Source files
------------

// File: rtl/mul16_seq.sv
// mul16_seq: sequential 16-bit shift-and-add multiplier.
// Produces the low 16 bits of a*b using one 16-bit adder stepped once per cycle.
// Handshake: start (accepted only while busy=0), busy during RUN, one-cycle done pulse.
// Optional macro MUL16_EARLY_EXIT_EN: leave RUN as soon as the remaining multiplier is zero.
module mul16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [15:0] mplier_q, mplier_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] out_q, out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [15:0] addend;
    logic [15:0] add_sum;
    logic        run_last;

    // add16 datapath: acc + (mplier[0] ? mcand : 0); the carry out of bit 15 is dropped.
    always_comb begin
        addend  = mplier_q[0] ? mcand_q : 16'h0000;
        add_sum = acc_q + addend;
    end

    // Decide whether the current RUN edge is the final one.
    always_comb begin
`ifdef MUL16_EARLY_EXIT_EN
        // Nothing left to add once the shifted multiplier becomes zero.
        run_last = (cnt_q == 4'd15) || (mplier_q[15:1] == 15'd0);
`else
        run_last = (cnt_q == 4'd15);
`endif
    end

    // Next-state and datapath updates; busy/done are derived from the next state so they
    // come straight out of flops.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = 16'h0000;
                    cnt_d    = 4'd0;
                    state_d  = StRun;
                end else begin
                    state_d  = StIdle;
                end
            end
            StRun: begin
                acc_d    = add_sum;
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                cnt_d    = cnt_q + 4'd1;
                if (run_last) begin
                    out_d   = add_sum;
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            acc_q    <= 16'h0000;
            cnt_q    <= 4'd0;
            out_q    <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign out  = out_q;

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: self-checking bench for mul16_seq with a product scoreboard.
// Honours MUL16_EARLY_EXIT_EN for the expected latencies.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          done_seen = 0;
    logic        prev_done = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int          lat;

    mul16_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected cycles from the accepting edge to the done cycle.
    function automatic int exp_latency(input logic [15:0] bv);
`ifdef MUL16_EARLY_EXIT_EN
        for (int i = 15; i >= 0; i--) begin
            if (bv[i]) return i + 2;
        end
        return 2;
`else
        return 17;
`endif
    endfunction

    // Monitor: pop the scoreboard on every done pulse.
    always @(posedge clk) begin
        #1;
        if (done) begin
            done_seen++;
            check_eq("done_not_busy", {31'd0, busy}, 32'd0);
            check_eq("done_single", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check_eq("product", {16'd0, out}, {16'd0, exp_v});
            end
        end
        prev_done = done;
    end

    // Drive one accepted request; returns at the negedge of the first RUN cycle.
    task automatic accept(input logic [15:0] av, input logic [15:0] bv, input bit push);
        logic [15:0] prod;
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        prod  = av * bv;
        if (push) exp_q.push_back(prod);
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        acc_cyc = cyc;
    endtask

    // Bounded wait for done; latency counted in cycles from the accepting edge.
    task automatic wait_done(output int l);
        l = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                l = cyc - acc_cyc + 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [15:0] ra, rb;
        reset = 1'b1;
        start = 1'b1;
        a     = 16'd3;
        b     = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        check_eq("reset_out", {16'd0, out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);

        // Basic product and latency.
        accept(16'd3, 16'd5, 1'b1);
        check_eq("run_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check_eq("lat_3x5", lat, exp_latency(16'd5));

        // Overflow cases.
        accept(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(lat);
        check_eq("lat_ffff", lat, exp_latency(16'hFFFF));
        accept(16'h0100, 16'h0100, 1'b1);
        wait_done(lat);
        check_eq("lat_0100", lat, exp_latency(16'h0100));

        // Small multipliers (early-exit boundaries).
        accept(16'd1234, 16'd1, 1'b1);
        wait_done(lat);
        check_eq("lat_b1", lat, exp_latency(16'd1));
        accept(16'd77, 16'd0, 1'b1);
        wait_done(lat);
        check_eq("lat_b0", lat, exp_latency(16'd0));

        // start during RUN is ignored.
        accept(16'd3, 16'd5, 1'b1);
`ifdef MUL16_EARLY_EXIT_EN
        repeat (1) @(negedge clk);
`else
        repeat (4) @(negedge clk);
`endif
        a     = 16'd7;
        b     = 16'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_eq("lat_ignore", lat, exp_latency(16'd5));
        @(negedge clk);
        check_eq("after_ign_busy", {31'd0, busy}, 32'd0);
        check_eq("after_ign_done", {31'd0, done}, 32'd0);
        check_eq("after_ign_out", {16'd0, out}, 32'd15);

        // Back-to-back: start held through the DONE cycle.
        accept(16'd3, 16'd5, 1'b1);
        repeat (exp_latency(16'd5) - 2) @(negedge clk);
        a     = 16'd2;
        b     = 16'd9;
        start = 1'b1;
        exp_q.push_back(16'd18);
        wait_done(lat);
        check_eq("lat_b2b_first", lat, exp_latency(16'd5));
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        acc_cyc = cyc;
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        check_eq("b2b_done", {31'd0, done}, 32'd0);
        check_eq("b2b_out_hold", {16'd0, out}, 32'd15);
        wait_done(lat);
        check_eq("lat_b2b_second", lat, exp_latency(16'd9));

        // Reset mid-RUN aborts without a done pulse.
        accept(16'h1234, 16'h0002, 1'b0);
`ifdef MUL16_EARLY_EXIT_EN
        repeat (1) @(negedge clk);
`else
        repeat (7) @(negedge clk);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_eq("abort_out", {16'd0, out}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        lat = done_seen;
        repeat (25) @(negedge clk);
        check_eq("abort_no_done", done_seen - lat, 0);

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            if (i == 0) rb = 16'h0005;
            accept(ra, rb, 1'b1);
            wait_done(lat);
            check_eq("lat_rand", lat, exp_latency(rb));
        end

        repeat (3) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
